// File: rtl/num_pkg.sv
// Shared definitions for num_join: FSM state encoding, nibble/byte widths
// and the width of the inter-byte gap counter.
package num_pkg;

    localparam int NIB_W     = 4;
    localparam int BYTE_W    = 8;
    localparam int GAP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/gap_timer.sv
// Down-counter that times the idle gap between two transmitted bytes.
// load presets the count; while enable is high it counts down, and done
// flags the last enabled cycle of the gap.
module gap_timer
    import num_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [GAP_CNT_W-1:0] load_value,
    input  logic                 enable,
    output logic                 done
);

    logic [GAP_CNT_W-1:0] count;

    // Preset on load, then count down one step per enabled clock.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - GAP_CNT_W'(1);
        end
    end

    assign done = enable && (count <= GAP_CNT_W'(1));

endmodule

// File: rtl/num_join.sv
// num_join: packs two nibbles into {m, l} and offers the byte to a UART
// transmitter with a valid/ready handshake, forcing GAP_CYCLES idle clocks
// between bytes. A one-entry pending register absorbs strobes that arrive
// while busy; the newest strobe wins and an overwrite pulses drop.
// Optional build macro NUM_JOIN_DEDUP_EN: strobes whose byte equals the last
// byte accepted by the transmitter are ignored.
module num_join
    import num_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NIB_W-1:0]  l,
    input  logic [NIB_W-1:0]  m,
    input  logic              in_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              drop
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES);

    state_t            state;
    logic [BYTE_W-1:0] in_byte;
    logic [BYTE_W-1:0] pending;
    logic              pending_full;
    logic              take;
    logic              gap_load;
    logic              gap_done;

`ifdef NUM_JOIN_DEDUP_EN
    logic [BYTE_W-1:0] last_sent;

    // Remember the last byte the transmitter actually accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sent <= '0;
        end else if (state == SEND && tx_ready) begin
            last_sent <= tx_data;
        end
    end
`endif

    // Assemble the incoming byte and decide whether this strobe is honoured.
    // NOTE: every output of an always_comb gets a default up front so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        in_byte = {m, l};
        take    = in_valid;
`ifdef NUM_JOIN_DEDUP_EN
        take    = in_valid && (in_byte != last_sent);
`endif
    end

    // The gap starts on the cycle the transmitter takes the byte.
    assign gap_load = (state == SEND) && tx_ready;

    gap_timer u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .enable     (state == GAP),
        .done       (gap_done)
    );

    // Handshake FSM with registered tx_data/tx_valid/busy/drop and the
    // pending register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            drop         <= 1'b0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    // A leftover pending byte (zero-gap build) goes first;
                    // a simultaneous strobe refills pending without a drop.
                    if (pending_full) begin
                        tx_data      <= pending;
                        tx_valid     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SEND;
                        pending_full <= take;
                        if (take) pending <= in_byte;
                    end else if (take) begin
                        tx_data  <= in_byte;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (take) begin
                        pending      <= in_byte;
                        pending_full <= 1'b1;
                        drop         <= pending_full;
                    end
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_done && pending_full) begin
                        tx_data      <= pending;
                        tx_valid     <= 1'b1;
                        state        <= SEND;
                        pending_full <= take;
                        if (take) pending <= in_byte;
                    end else begin
                        if (take) begin
                            pending      <= in_byte;
                            pending_full <= 1'b1;
                            drop         <= pending_full;
                        end
                        if (gap_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/num_join.md
NUM_JOIN -- requirements
Module: num_join

Interface
REQ-001 Parameter: GAP_CYCLES, default 4, idle clocks forced between two transmitted bytes (0..255).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: l  input  4  low nibble to combine.
REQ-005 Port: m  input  4  high nibble to combine.
REQ-006 Port: in_valid  input  1  one-clock strobe; l/m valid this cycle.
REQ-007 Port: tx_data  output  8  assembled byte toward the UART transmitter.
REQ-008 Port: tx_valid  output  1  tx_data offered; held until accepted.
REQ-009 Port: tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: drop  output  1  one-clock pulse when a pending byte is overwritten.

Function
REQ-012 Byte assembly SHALL be {m, l}: m in bits 7:4, l in bits 3:0.
REQ-013 FSM states SHALL be IDLE, SEND, GAP.
REQ-014 IDLE: in_valid SHALL load {m,l} into tx_data and enter SEND next clock; tx_valid rises one clock after in_valid.
REQ-015 SEND: tx_valid SHALL be 1 and tx_data stable until tx_valid&tx_ready; on that cycle go to GAP, or to IDLE if GAP_CYCLES==0.
REQ-016 GAP: 8-bit counter SHALL count GAP_CYCLES clocks with tx_valid low, then go to IDLE, or to SEND if pending is full.
REQ-017 One-entry pending register: in_valid in SEND or GAP SHALL store {m,l} in pending and set pending_full.
REQ-018 in_valid while pending_full SHALL overwrite pending (newest wins) and pulse drop for one clock.
REQ-019 Leaving GAP with pending_full SHALL move pending to tx_data and clear pending_full.
REQ-020 in_valid on the same cycle pending is consumed SHALL become the new pending; no drop pulse.
REQ-021 In SEND, in_valid together with tx_valid&tx_ready SHALL go to pending; the accepted byte is unaffected.
REQ-022 tx_ready while tx_valid is low SHALL be ignored.
REQ-023 busy SHALL be a registered output equal to (state != IDLE).

Reset
REQ-024 Asserting reset (low) SHALL immediately clear state to IDLE, tx_data to 0x00, tx_valid, busy, drop, pending_full and the gap counter to 0, and the last-sent register to 0x00.
REQ-025 Reset asserted during SEND SHALL abandon the byte; tx_valid falls asynchronously.
REQ-026 After reset release, the first in_valid SHALL be honoured on the first rising edge.

Configuration
REQ-027 Macro NUM_JOIN_DEDUP_EN defined: in_valid with {m,l} equal to the last byte accepted by tx_ready SHALL be ignored (no load, no pending write, no drop); after reset the last-sent value is 0x00, so 0x00 is suppressed until another byte has been sent.
REQ-028 Macro NUM_JOIN_DEDUP_EN undefined: every in_valid SHALL be processed per REQ-014..REQ-021, and the last-sent register SHALL not exist.

Structure
REQ-029 Shared package num_pkg SHALL hold the FSM state encoding (IDLE=0, SEND=1, GAP=2), the nibble and byte width constants, and the GAP counter width.
REQ-030 The gap counter SHALL be a sub-module gap_timer (load, count-done); no other sub-modules.

Verification
REQ-031 l=0x5, m=0xA, in_valid for 1 clk, tx_ready=1 -> tx_data=0xA5, tx_valid high exactly 1 clk, busy low after GAP_CYCLES+2 clks.
REQ-032 tx_ready=0 for 10 clks after SEND entry -> tx_valid and tx_data=0xA5 stable for 10 clks; accepted on the 11th.
REQ-033 Bytes 0x12, 0x34, 0x56 strobed on consecutive clks with tx_ready=0 -> 0x12 sent, then 0x56; one drop pulse (0x34 overwritten).
REQ-034 Reset pulled low mid-SEND -> tx_valid=0, busy=0 with no clock edge; next in_valid 0x0F is transmitted normally.
REQ-035 NUM_JOIN_DEDUP_EN defined: send 0x77, then strobe 0x77 again -> no second tx_valid; strobe 0x78 -> sent.
REQ-036 GAP_CYCLES=0, back-to-back strobes with tx_ready=1 -> one byte accepted every 2 clks, no drop.
